// File: rtl/gf_pkg.sv
// Shared GF(2) arithmetic constants and helpers.
// Field polynomials are listed with the x^n term included.
package gf_pkg;

    localparam logic [4:0] GF_POLY_4 = 5'b10011;
    localparam logic [8:0] GF_POLY_8 = 9'h11B;

    function automatic int clmul_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/gf_clmul.sv
// Combinational carry-less multiplier array.
// Each partial product a[i]&b[j] is XOR-accumulated into bit i+j.
module gf_clmul
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]                 a,
    input  logic [DATA_WIDTH-1:0]                 b,
    output logic [clmul_width(DATA_WIDTH)-1:0]    p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int j = 0; j < DATA_WIDTH; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
    end

endmodule

// File: rtl/gf_mult_top.sv
// Registered carry-less multiplier with optional modulo-POLY reduction.
// Define GF_MULT_REDUCE_EN to build the reduction stage and out_red port.
module gf_mult_top
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 4
`ifdef GF_MULT_REDUCE_EN
    ,
    parameter logic [DATA_WIDTH:0] POLY = GF_POLY_4
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH-1:0]               a,
    input  logic [DATA_WIDTH-1:0]               b,
    output logic [clmul_width(DATA_WIDTH)-1:0]  out,
`ifdef GF_MULT_REDUCE_EN
    output logic [DATA_WIDTH-1:0]               out_red,
`endif
    output logic                                out_valid
);

    localparam int PW = clmul_width(DATA_WIDTH);

    logic [PW-1:0] prod;
    logic [PW-1:0] out_d, out_q;
    logic          vld_d, vld_q;

    gf_clmul #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clmul (
        .a (a),
        .b (b),
        .p (prod)
    );

    always_comb begin
        vld_d = in_valid;
        out_d = out_q;
        if (in_valid) begin
            out_d = prod;
        end
    end

`ifdef GF_MULT_REDUCE_EN
    logic [PW-1:0]         rem;
    logic [PW-1:0]         poly_ext;
    logic [DATA_WIDTH-1:0] red_d, red_q;

    assign poly_ext = {{(DATA_WIDTH-1){1'b0}}, POLY};

    // Long division from the top degree down; the x^DATA_WIDTH term cancels each step.
    always_comb begin
        rem = prod;
        for (int d = PW - 2; d >= DATA_WIDTH; d--) begin
            if (rem[d]) begin
                rem = rem ^ (poly_ext << (d - DATA_WIDTH));
            end
        end
        red_d = red_q;
        if (in_valid) begin
            red_d = rem[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_q <= '0;
        end else begin
            red_q <= red_d;
        end
    end

    assign out_red = red_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_gf_mult_top.sv
// Bench for gf_mult_top: polynomial model, per-cycle compare, directed literals.
// Works with GF_MULT_REDUCE_EN defined or undefined.
module tb_gf_mult_top;

    localparam int         W    = 4;
    localparam logic [4:0] POLY = 5'b10011;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] out;
    logic           out_valid;
`ifdef GF_MULT_REDUCE_EN
    logic [W-1:0]   out_red;
    logic [W-1:0]   exp_red;
`endif

    logic [2*W-1:0] exp_out;
    logic           exp_valid;
    logic           chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf_mult_top #(
        .DATA_WIDTH (W)
`ifdef GF_MULT_REDUCE_EN
        ,
        .POLY       (POLY)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out       (out),
`ifdef GF_MULT_REDUCE_EN
        .out_red   (out_red),
`endif
        .out_valid (out_valid)
    );

    // Shift-and-add polynomial product
    function automatic logic [2*W-1:0] ref_clmul(input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (y[i]) r = r ^ ({{W{1'b0}}, x} << i);
        end
        return r;
    endfunction

`ifdef GF_MULT_REDUCE_EN
    // Field multiply keeping the running multiplicand reduced (xtime method)
    function automatic logic [W-1:0] ref_gfmul(input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        logic [W:0]   m;
        logic [W-1:0] r;
        m = {1'b0, x};
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (y[i]) r = r ^ m[W-1:0];
            m = m << 1;
            if (m[W]) m = m ^ POLY;
        end
        return r;
    endfunction
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_out   <= '0;
            exp_valid <= 1'b0;
`ifdef GF_MULT_REDUCE_EN
            exp_red   <= '0;
`endif
        end else if (in_valid) begin
            exp_out   <= ref_clmul(a, b);
            exp_valid <= 1'b1;
`ifdef GF_MULT_REDUCE_EN
            exp_red   <= ref_gfmul(a, b);
`endif
        end else begin
            exp_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out", 32'(out), 32'(exp_out));
            chk("cyc_valid", 32'(out_valid), 32'(exp_valid));
            chk("cyc_msb0", 32'(out[2*W-1]), 32'd0);
`ifdef GF_MULT_REDUCE_EN
            chk("cyc_red", 32'(out_red), 32'(exp_red));
`endif
        end
    end

    task automatic step(input logic v, input logic [W-1:0] x,
                        input logic [W-1:0] y);
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int eo, input int er,
                       input logic ev);
        chk({name, "_out"}, 32'(out), eo);
        chk({name, "_valid"}, 32'(out_valid), 32'(ev));
`ifdef GF_MULT_REDUCE_EN
        if (er >= 0) chk({name, "_red"}, 32'(out_red), er);
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'd15;
        b        = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit("rst", 0, 0, 1'b0);

        rst_n = 1'b1;
        step(1'b0, 4'd15, 4'd15);
        lit("post_rst", 0, 0, 1'b0);

        step(1'b1, 4'd12, 4'd10);
        lit("p12x10", 120, 1, 1'b1);
        step(1'b1, 4'd5, 4'd9);
        lit("p5x9", 45, 11, 1'b1);
        step(1'b1, 4'd15, 4'd13);
        lit("p15x13", 75, 7, 1'b1);
        step(1'b0, 4'd3, 4'd3);
        lit("hold", 75, 7, 1'b0);

        step(1'b1, 4'd0, 4'd13);
        lit("zero", 0, 0, 1'b1);
        step(1'b1, 4'd1, 4'd13);
        lit("one_a", 13, 13, 1'b1);
        step(1'b1, 4'd13, 4'd1);
        lit("one_b", 13, 13, 1'b1);

        step(1'b1, 4'd15, 4'd13);
        lit("pre_mrst", 75, 7, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 4'd12, 4'd10);
        lit("mrst", 0, 0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 4'd0, 4'd0);
        lit("mrst_after1", 0, 0, 1'b0);
        step(1'b0, 4'd0, 4'd0);
        lit("mrst_after2", 0, 0, 1'b0);

        for (int i = 0; i < 256; i++) begin
            step(1'b1, 4'(i >> 4), 4'(i));
        end
        lit("last_15x15", 85, -1, 1'b1);
        step(1'b0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 4'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
